reqack_stream_source: RTL

//   Responder end of the req/ack dataflow handshake: buffers words pushed on a valid/ready

---
 rtl/reqack_stream_source_if.sv | 31 +++
 rtl/reqack_stream_source.sv | 94 +++++++++
 2 files changed

// File: rtl/reqack_stream_source_if.sv
// rtl/reqack_stream_source_if.sv - write-port and req/ack serve-port bundle for reqack_stream_source
interface reqack_stream_source_if #(
    parameter int data_width = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] in_data;
    logic                  req;
    logic                  ack;
    logic [data_width-1:0] dout;

    // Producer/initiator side: pushes words and requests deliveries
    modport master (
        output in_valid,
        output in_data,
        output req,
        input  in_ready,
        input  ack,
        input  dout
    );

    // Stream source side: accepts words and answers requests
    modport slave (
        input  in_valid,
        input  in_data,
        input  req,
        output in_ready,
        output ack,
        output dout
    );
endinterface

// File: rtl/reqack_stream_source.sv
// rtl/reqack_stream_source.sv - FIFO-backed req/ack responder fed by a valid/ready write port
module reqack_stream_source #(
    parameter int data_width = 32,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    reqack_stream_source_if.slave   bus,
    output logic [31:0]             count,
    output logic [addr_width:0]     level
);
    localparam logic [addr_width:0] level_full = (addr_width + 1)'(depth);

    logic [data_width-1:0] mem [depth];

    logic [addr_width-1:0] rd_q, rd_d;
    logic [addr_width-1:0] wr_q, wr_d;
    logic [addr_width:0]   level_q, level_d;
    logic                  ack_q, ack_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [31:0]           count_q, count_d;

    logic push;
    logic pop;

    // Handshake decode: ready comes straight from the registered level, and a serve
    // is only allowed when no ack is currently showing so pulses stay one cycle wide
    always_comb begin
        bus.in_ready = (level_q != level_full);
        push         = bus.in_valid & bus.in_ready;
        pop          = bus.req & ~ack_q & (level_q != '0);
    end

    // Next-state for pointers, occupancy, delivered-word register and counter
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        ack_d   = 1'b0;
        dout_d  = dout_q;
        count_d = count_q;

        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d    = rd_q + 1'b1;
            ack_d   = 1'b1;
            dout_d  = mem[rd_q];
            count_d = count_q + 32'd1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (rst) begin
            rd_d    = '0;
            wr_d    = '0;
            level_d = '0;
            ack_d   = 1'b0;
            dout_d  = '0;
            count_d = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        level_q <= level_d;
        ack_q   <= ack_d;
        dout_q  <= dout_d;
        count_q <= count_d;
    end

    // Storage array; not cleared by reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= bus.in_data;
        end
    end

    // Output wiring
    always_comb begin
        bus.ack  = ack_q;
        bus.dout = dout_q;
        count    = count_q;
        level    = level_q;
    end
endmodule
